rsa_decryptor: RTL
==================

Name: rsa_decryptor

Overview:
- Decrypt side paired with RSA_Encryptor: plain_val = cipher_val^private_key mod public_key.
- Uses MSB-first square-and-multiply exponentiation. Each modular multiply is a bit-serial interleaved shift/add/subtract, so no wide multiplier and no full-power intermediate.
- Same start/cal_done handshake as RSA_Encryptor, so a top level can drop either block into a round-trip loop.

Parameters:
- WIDTH, 64, operand width of key, modulus, cipher and plaintext.
- CNT_W, 7, width of the bit counters; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; operands are sampled on the same edge.
- private_key  in  WIDTH  decryption exponent d.
- public_key  in  WIDTH  modulus n.
- cipher_val  in  WIDTH  ciphertext c.
- busy  out  1  high from the cycle after an accepted start until cal_done rises.
- cal_done  out  1  level; high when a result is valid, held until the next accepted start or rst.
- cal_err  out  1  qualified by cal_done; high means the operands were invalid.
- plain_val  out  WIDTH  result; held while cal_done=1.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, cal_done=0, cal_err=0, plain_val=0. All internal registers clear. An in-flight operation is abandoned, and no cal_done follows.
- States: IDLE, LOAD, SQR, MUL, NEXT, DONE.
- IDLE:
  - start=1 latches d, n and c, clears cal_done and cal_err, and goes to LOAD.
  - start while busy is ignored.
  - start in DONE is accepted like IDLE.
- LOAD (1 cycle):
  - If n<2 or c>=n: cal_err=1, plain_val=0, go to DONE.
  - Otherwise: acc=1, base=c, exponent bit index i=WIDTH-1, go to SQR.
- SQR (exactly WIDTH cycles): computes acc=acc*acc mod n with the interleaved algorithm.
  - Per cycle, multiplier bit k runs from WIDTH-1 down to 0.
  - Each cycle: r=2r; if r>=n then r=r-n; if bit k set then r=r+a; if r>=n then r=r-n.
  - r is held in WIDTH+2 bits so there is no overflow.
  - After the last cycle: if d[i]=1 go to MUL, else go to NEXT.
- MUL (exactly WIDTH cycles): acc=acc*base mod n, same datapath, then go to NEXT.
- NEXT (0 extra cycles; folded into the last SQR/MUL cycle):
  - If i==0 go to DONE.
  - Otherwise i=i-1 and go to SQR.
- DONE: plain_val=acc (or 0 on error), cal_done=1, busy=0. Stays here until start or rst.
- Latency, counted from the start edge to the cal_done rising edge:
  - L = 2 + WIDTH*(WIDTH + popcount(d)) cycles.
  - Error path: L = 2.
- d=0 gives plain_val=1, since n>=2 on the non-error path.
- Operands are not re-read after the start edge; input changes while busy have no effect.
- Result is always < n.

Optional Feature:
- Macro: RSA_DEC_LZ_SKIP_EN.
- Defined: LOAD sets i to the index of the most significant set bit of d, so leading-zero squarings (acc=1) are skipped.
  - Latency: L = 2 + WIDTH*(msb(d)+1 + popcount(d)).
  - d=0 goes straight to DONE with plain_val=1, L=2.
  - Results are identical to the macro-undefined build.
- Undefined: all WIDTH exponent bits are processed; latency is fixed by popcount(d) only.

Test Plan:
- WIDTH=64, d=7, n=33, c=3, one-cycle start:
  - Undefined build: plain_val=9, cal_err=0, cal_done rises exactly 4290 cycles after start.
  - Macro defined: cal_done rises after 2+64*6=386 cycles.
- Round trip, d=2753, n=3233, c=2790: plain_val=65. Also c=0 gives 0, and c=1 gives 1.
- Error cases:
  - n=1, d=5, c=0: cal_err=1, plain_val=0, cal_done 2 cycles after start.
  - n=33, c=40: cal_err=1.
- d=0, n=33, c=20: plain_val=1, cal_err=0.
- Busy-start handling:
  - Assert start again mid-SQR with different operands: ignored, and the first result (9) is delivered.
  - Then start in DONE: cal_done drops the next cycle, and the new result appears.
- Reset mid-MUL:
  - rst pulsed for 6 ns asynchronously (between clock edges): all outputs are 0 immediately.
  - No cal_done without a new start; a subsequent start with d=7, n=33, c=3 yields 9.

Source files
------------

// File: rtl/rsa_decryptor_if.sv
// rsa_decryptor_if: start/cal_done handshake bundle for the RSA decrypt core.
// Handshake: the master pulses start for one cycle with operands valid on the
// same edge; the slave raises busy the next cycle, then holds cal_done high
// (with cal_err and plain_val valid) until the next accepted start or reset.
`timescale 1ns/1ps
interface rsa_decryptor_if #(parameter int WIDTH = 64);
   logic             start;
   logic [WIDTH-1:0] private_key;
   logic [WIDTH-1:0] public_key;
   logic [WIDTH-1:0] cipher_val;
   logic             busy;
   logic             cal_done;
   logic             cal_err;
   logic [WIDTH-1:0] plain_val;
   logic [2:0]       dbg_state;

   modport master (
      output start, private_key, public_key, cipher_val,
      input  busy, cal_done, cal_err, plain_val, dbg_state
   );

   modport slave (
      input  start, private_key, public_key, cipher_val,
      output busy, cal_done, cal_err, plain_val, dbg_state
   );
endinterface

// File: rtl/rsa_decryptor.sv
// rsa_decryptor: plain = cipher^d mod n by MSB-first square-and-multiply.
// Each modular multiply is bit-serial interleaved shift/add/subtract, one
// multiplier bit per cycle, WIDTH cycles per multiply.
// Optional build macro RSA_DEC_LZ_SKIP_EN: start the exponent scan at the
// most significant set bit of d, skipping leading squarings of acc=1.
`timescale 1ns/1ps
module rsa_decryptor #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   rsa_decryptor_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SQR, S_MUL, S_NEXT, S_DONE
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] KTOP = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_d, r_n, r_c, r_acc, r_plain;
   logic [WIDTH+1:0] r_r;
   logic [CNT_W-1:0] r_k, r_i;
   logic             r_err, r_busy, r_done, r_cerr;

   logic [WIDTH-1:0] w_a;
   logic             w_bit, w_dbit;
   logic [WIDTH+1:0] w_n_ext, w_dbl, w_red1, w_add, w_red2;

   // One interleaved step: r = 2r mod n, then add multiplicand if bit k set, mod n.
   always_comb begin
      w_a     = (r_state == S_MUL) ? r_c : r_acc;
      w_bit   = |(r_acc & (ONE << r_k));
      w_dbit  = |(r_d & (ONE << r_i));
      w_n_ext = {2'b00, r_n};
      w_dbl   = r_r << 1;
      w_red1  = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
      w_add   = w_red1 + (w_bit ? {2'b00, w_a} : '0);
      w_red2  = (w_add >= w_n_ext) ? (w_add - w_n_ext) : w_add;
   end

`ifdef RSA_DEC_LZ_SKIP_EN
   logic [CNT_W-1:0] w_msb;

   // Index of the highest set bit of the latched exponent (0 when d=0).
   always_comb begin
      w_msb = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if (r_d[j]) w_msb = CNT_W'(j);
      end
   end
`endif

   // Control FSM with registered handshake outputs and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_d     <= '0;
         r_n     <= '0;
         r_c     <= '0;
         r_acc   <= '0;
         r_r     <= '0;
         r_k     <= '0;
         r_i     <= '0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cerr  <= 1'b0;
         r_plain <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (r_state == S_DONE) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_cerr  <= r_err;
                  r_plain <= r_err ? '0 : r_acc;
               end
               // A new request is accepted from idle or from a finished result.
               if (bus.start) begin
                  r_d     <= bus.private_key;
                  r_n     <= bus.public_key;
                  r_c     <= bus.cipher_val;
                  r_err   <= 1'b0;
                  r_done  <= 1'b0;
                  r_cerr  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_r <= '0;
               r_k <= KTOP;
               if (r_n < WIDTH'(2) || r_c >= r_n) begin
                  r_err   <= 1'b1;
                  r_acc   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_acc <= ONE;
`ifdef RSA_DEC_LZ_SKIP_EN
                  r_i     <= w_msb;
                  r_state <= (r_d == '0) ? S_DONE : S_SQR;
`else
                  r_i     <= KTOP;
                  r_state <= S_SQR;
`endif
               end
            end
            S_SQR, S_MUL: begin
               r_r <= w_red2;
               r_k <= r_k - 1'b1;
               // Last multiplier bit: commit product and fold the NEXT decision in.
               if (r_k == '0) begin
                  r_acc <= w_red2[WIDTH-1:0];
                  r_r   <= '0;
                  r_k   <= KTOP;
                  if (r_state == S_SQR && w_dbit) begin
                     r_state <= S_MUL;
                  end else if (r_i == '0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_i     <= r_i - 1'b1;
                     r_state <= S_SQR;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.cal_done  = r_done;
   assign bus.cal_err   = r_cerr;
   assign bus.plain_val = r_plain;
   assign bus.dbg_state = r_state;

endmodule
